// File: rtl/soc_trace_nop_decoder_if.sv
// Trace-in / event-out bundle for the per-core l.nop trace decoder.
// The master side is the trace producer plus event consumer; the slave side is the decoder.
interface soc_trace_nop_decoder_if;
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [31:0] trace_insn;
    logic        trace_wben;
    logic [4:0]  trace_wbreg;
    logic [31:0] trace_wbdata;

    logic        evt_valid;
    logic        evt_ready;
    logic [15:0] evt_code;
    logic [31:0] evt_data;
    logic [31:0] evt_pc;
    logic [15:0] evt_core_id;

    logic        terminated;
    logic [31:0] exit_code;
    logic [15:0] drop_count;

    modport master (
        output trace_valid, trace_pc, trace_insn, trace_wben, trace_wbreg, trace_wbdata,
        output evt_ready,
        input  evt_valid, evt_code, evt_data, evt_pc, evt_core_id,
        input  terminated, exit_code, drop_count
    );

    modport slave (
        input  trace_valid, trace_pc, trace_insn, trace_wben, trace_wbreg, trace_wbdata,
        input  evt_ready,
        output evt_valid, evt_code, evt_data, evt_pc, evt_core_id,
        output terminated, exit_code, drop_count
    );
endinterface

// File: rtl/soc_trace_nop_decoder.sv
// Per-core trace consumer: shadows r3, turns l.nop K (K!=0) into buffered events,
// and latches program termination with its exit code.
module soc_trace_nop_decoder #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CORE_ID    = 0,
    parameter logic [15:0] TERM_NOP   = 16'h0001
) (
    input logic                    clk,
    input logic                    rst_n,
    soc_trace_nop_decoder_if.slave bus
);

    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CODE_W  = 16;
    localparam int unsigned WORD_W  = 32;
    localparam logic [7:0]  NOP_OPC = 8'h15;
    localparam logic [4:0]  R3_IDX  = 5'd3;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [WORD_W-1:0] data;
        logic [WORD_W-1:0] pc;
    } evt_t;

    // Architectural state
    logic [WORD_W-1:0] r3_q;
    logic              terminated_q;
    logic [WORD_W-1:0] exit_code_q;
    logic [CODE_W-1:0] drop_count_q;

    // Event buffer state
    evt_t              mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              valid_q;

    // Decode signals
    logic              active_c;
    logic              is_nop_c;
    logic [CODE_W-1:0] nop_k_c;
    logic              evt_c;
    logic              term_c;
    logic              r3_wr_c;
    logic              full_c;
    logic              pop_c;
    logic              push_c;
    logic              drop_c;
    logic [CNT_W-1:0]  count_next_c;
    evt_t              evt_in_c;
    evt_t              head_c;

    // Opcode byte and K are the only fields of the instruction word that matter
    logic unused_insn_bits;
    assign unused_insn_bits = ^bus.trace_insn[23:16];

    // Trace decode; once terminated, all trace input is ignored until reset
    always_comb begin
        active_c = bus.trace_valid & ~terminated_q;
        is_nop_c = active_c & (bus.trace_insn[31:24] == NOP_OPC);
        nop_k_c  = bus.trace_insn[15:0];
        evt_c    = is_nop_c & (nop_k_c != '0);
        term_c   = evt_c & (nop_k_c == TERM_NOP);
        r3_wr_c  = active_c & bus.trace_wben & (bus.trace_wbreg == R3_IDX);
    end

    // Event payload uses r3 as it was before any same-cycle write-back
    always_comb begin
        evt_in_c      = '0;
        evt_in_c.code = nop_k_c;
        evt_in_c.data = r3_q;
        evt_in_c.pc   = bus.trace_pc;
    end

    // A full buffer still takes a push when the head is popped on the same edge
    always_comb begin
        full_c = (count_q == CNT_W'(FIFO_DEPTH));
        pop_c  = valid_q & bus.evt_ready;
        push_c = evt_c & (~full_c | pop_c);
        drop_c = evt_c & full_c & ~pop_c;
    end

    always_comb begin
        count_next_c = count_q;
        if (push_c && !pop_c) begin
            count_next_c = count_q + CNT_W'(1);
        end else if (!push_c && pop_c) begin
            count_next_c = count_q - CNT_W'(1);
        end
    end

    // Shadow r3 plus sticky termination state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r3_q         <= '0;
            terminated_q <= 1'b0;
            exit_code_q  <= '0;
        end else begin
            if (r3_wr_c) begin
                r3_q <= bus.trace_wbdata;
            end
            if (term_c) begin
                terminated_q <= 1'b1;
                exit_code_q  <= r3_q;
            end
        end
    end

    // Dropped-event counter saturates rather than wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count_q <= '0;
        end else if (drop_c && (drop_count_q != '1)) begin
            drop_count_q <= drop_count_q + CODE_W'(1);
        end
    end

    // Buffer pointers and occupancy; power-of-two depth makes pointer wrap implicit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_next_c;
            valid_q <= (count_next_c != '0);
        end
    end

    // Payload storage needs no reset: the head is masked while the buffer is empty
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr_q] <= evt_in_c;
        end
    end

    always_comb begin
        head_c = '0;
        if (valid_q) begin
            head_c = mem[rd_ptr_q];
        end
    end

    assign bus.evt_valid   = valid_q;
    assign bus.evt_code    = head_c.code;
    assign bus.evt_data    = head_c.data;
    assign bus.evt_pc      = head_c.pc;
    assign bus.evt_core_id = CODE_W'(CORE_ID);
    assign bus.terminated  = terminated_q;
    assign bus.exit_code   = exit_code_q;
    assign bus.drop_count  = drop_count_q;

endmodule

// File: tb/tb_soc_trace_nop_decoder.sv
// Bench for soc_trace_nop_decoder: directed scenarios plus randomized trace traffic,
// checked every cycle against a queue-based event model.
module tb_soc_trace_nop_decoder;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CORE  = 7;
    localparam logic [15:0] TERM  = 16'h0001;

    typedef struct {
        logic [15:0] code;
        logic [31:0] data;
        logic [31:0] pc;
    } ev_t;

    logic clk;
    logic rst_n;
    soc_trace_nop_decoder_if bus ();

    soc_trace_nop_decoder #(
        .FIFO_DEPTH (DEPTH),
        .CORE_ID    (CORE),
        .TERM_NOP   (TERM)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Reference model state
    ev_t         m_q[$];
    logic [31:0] m_r3;
    bit          m_term;
    logic [31:0] m_exit;
    logic [15:0] m_drop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_r3   = '0;
        m_term = 1'b0;
        m_exit = '0;
        m_drop = '0;
    endtask

    // One clock edge of the specified behaviour
    task automatic model_edge(input logic v, input logic [31:0] pc, input logic [31:0] insn,
                              input logic we, input logic [4:0] wr, input logic [31:0] wd,
                              input logic rdy);
        ev_t ev;
        if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
        if (v && !m_term) begin
            if (insn[31:24] == 8'h15 && insn[15:0] != 16'h0) begin
                ev.code = insn[15:0];
                ev.data = m_r3;
                ev.pc   = pc;
                if (m_q.size() < DEPTH) m_q.push_back(ev);
                else if (m_drop != 16'hFFFF) m_drop++;
                if (insn[15:0] == TERM) begin
                    m_term = 1'b1;
                    m_exit = m_r3;
                end
            end
            if (we && wr == 5'd3) m_r3 = wd;
        end
    endtask

    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] insn,
                        input logic we, input logic [4:0] wr, input logic [31:0] wd,
                        input logic rdy);
        bus.trace_valid  = v;
        bus.trace_pc     = pc;
        bus.trace_insn   = insn;
        bus.trace_wben   = we;
        bus.trace_wbreg  = wr;
        bus.trace_wbdata = wd;
        bus.evt_ready    = rdy;
        @(posedge clk);
        model_edge(v, pc, insn, we, wr, wd, rdy);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.trace_valid  = 1'b0;
        bus.trace_pc     = '0;
        bus.trace_insn   = '0;
        bus.trace_wben   = 1'b0;
        bus.trace_wbreg  = '0;
        bus.trace_wbdata = '0;
        bus.evt_ready    = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            chk("evt_valid", 32'(bus.evt_valid), 32'(m_q.size() != 0));
            if (m_q.size() != 0) begin
                chk("evt_code", 32'(bus.evt_code), 32'(m_q[0].code));
                chk("evt_data", bus.evt_data, m_q[0].data);
                chk("evt_pc", bus.evt_pc, m_q[0].pc);
            end
            chk("evt_core_id", 32'(bus.evt_core_id), 32'(16'(CORE)));
            chk("terminated", 32'(bus.terminated), 32'(m_term));
            chk("exit_code", bus.exit_code, m_exit);
            chk("drop_count", 32'(bus.drop_count), 32'(m_drop));
        end
    end

    initial begin
        logic [31:0] insn;
        logic [15:0] k;
        model_clear();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_evt_valid", 32'(bus.evt_valid), 32'h0);
        chk("rst_evt_code", 32'(bus.evt_code), 32'h0);
        chk("rst_evt_data", bus.evt_data, 32'h0);
        chk("rst_evt_pc", bus.evt_pc, 32'h0);
        chk("rst_terminated", 32'(bus.terminated), 32'h0);
        chk("rst_drop_count", 32'(bus.drop_count), 32'h0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // Basic event: r3 = 0x41 then l.nop 4
        step(1, 32'h0FC, 32'h9C60_0041, 1, 5'd3, 32'h41, 1);
        step(1, 32'h100, 32'h1500_0004, 0, 5'd0, 32'h0, 1);
        chk("t1_valid", 32'(bus.evt_valid), 32'h1);
        chk("t1_code", 32'(bus.evt_code), 32'h4);
        chk("t1_data", bus.evt_data, 32'h41);
        chk("t1_pc", bus.evt_pc, 32'h100);
        chk("t1_core", 32'(bus.evt_core_id), 32'h7);

        // Plain nops / other insns / writes to r4 leave r3 alone; same-cycle r3 write not reflected
        step(1, 32'h104, 32'h1500_0000, 1, 5'd4, 32'h99, 1);
        step(1, 32'h108, 32'h9C80_0077, 1, 5'd4, 32'h77, 1);
        chk("t2_novalid", 32'(bus.evt_valid), 32'h0);
        step(1, 32'h10C, 32'h1500_0002, 1, 5'd3, 32'h55, 0);
        chk("t2_code", 32'(bus.evt_code), 32'h2);
        chk("t2_data", bus.evt_data, 32'h41);
        step(0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 1);
        step(1, 32'h110, 32'h1500_0002, 0, 5'd0, 32'h0, 0);
        chk("t2_data_new", bus.evt_data, 32'h55);
        step(0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 1);

        // Termination, then trace input ignored
        step(1, 32'h2FC, 32'h9C60_0000, 1, 5'd3, 32'h0, 1);
        step(1, 32'h300, 32'h1500_0001, 0, 5'd0, 32'h0, 0);
        chk("t3_term", 32'(bus.terminated), 32'h1);
        chk("t3_exit", bus.exit_code, 32'h0);
        chk("t3_code", 32'(bus.evt_code), 32'h1);
        step(1, 32'h304, 32'h9C60_0005, 1, 5'd3, 32'h5, 1);
        step(1, 32'h308, 32'h1500_0004, 0, 5'd0, 32'h0, 1);
        chk("t3_noevt", 32'(bus.evt_valid), 32'h0);
        chk("t3_exit_hold", bus.exit_code, 32'h0);

        // Overflow: six nops into a four-deep buffer
        do_reset();
        for (int i = 0; i < 6; i++) step(1, 32'h400 + 32'(4 * i), 32'h1500_0004, 0, 5'd0, 32'h0, 0);
        chk("t4_drop", 32'(bus.drop_count), 32'h2);
        chk("t4_head_pc", bus.evt_pc, 32'h400);
        // Full buffer with simultaneous pop accepts the push
        step(1, 32'h500, 32'h1500_0002, 0, 5'd0, 32'h0, 1);
        chk("t4_drop_hold", 32'(bus.drop_count), 32'h2);
        chk("t4_head_pc2", bus.evt_pc, 32'h404);
        for (int i = 0; i < 4; i++) begin
            step(0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 1);
            if (i == 2) chk("t4_last_pc", bus.evt_pc, 32'h500);
        end
        chk("t4_drained", 32'(bus.evt_valid), 32'h0);

        // Asynchronous reset with buffered events and termination latched
        do_reset();
        step(1, 32'h5FC, 32'h9C60_1234, 1, 5'd3, 32'h1234, 0);
        step(1, 32'h600, 32'h1500_0004, 0, 5'd0, 32'h0, 0);
        step(1, 32'h604, 32'h1500_0004, 0, 5'd0, 32'h0, 0);
        step(1, 32'h608, 32'h1500_0001, 0, 5'd0, 32'h0, 0);
        chk("t5_term", 32'(bus.terminated), 32'h1);
        chk("t5_exit", bus.exit_code, 32'h1234);
        idle_inputs();
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        chk("t5_async_valid", 32'(bus.evt_valid), 32'h0);
        chk("t5_async_code", 32'(bus.evt_code), 32'h0);
        chk("t5_async_data", bus.evt_data, 32'h0);
        chk("t5_async_pc", bus.evt_pc, 32'h0);
        chk("t5_async_term", 32'(bus.terminated), 32'h0);
        chk("t5_async_exit", bus.exit_code, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 32'h700, 32'h1500_0001, 0, 5'd0, 32'h0, 0);
        chk("t5_reterm", 32'(bus.terminated), 32'h1);
        chk("t5_recode", 32'(bus.evt_code), 32'h1);
        chk("t5_repc", bus.evt_pc, 32'h700);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0 || (m_term && $urandom_range(0, 15) == 0)) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 9) < 4) begin
                    case ($urandom_range(0, 9))
                        0, 1:    k = 16'h0000;
                        2:       k = TERM;
                        3, 4:    k = 16'h0002;
                        5, 6:    k = 16'h0004;
                        default: k = 16'($urandom);
                    endcase
                    insn = {8'h15, 8'($urandom), k};
                end else begin
                    insn = $urandom;
                    if (insn[31:24] == 8'h15) insn[31] = 1'b1;
                end
                step(1'($urandom_range(0, 9) < 8), $urandom, insn, 1'($urandom),
                     ($urandom_range(0, 1) == 0) ? 5'd3 : 5'($urandom), $urandom,
                     1'($urandom_range(0, 2) == 0));
            end
        end

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
